// File: rtl/aes_encrypt_iter_if.sv
// Handshake bundle for the iterative AES-128 encryption engine.
//   in_valid / in_ready   : plaintext + key offer and acceptance
//   plaintext, key        : 128-bit input block and cipher key (byte 0 = [127:120])
//   out_valid / out_ready : ciphertext offer and consumption
//   ciphertext            : 128-bit result, zero whenever out_valid is low
//   busy                  : engine is working on or holding a block
// master = block producer / result consumer, slave = the engine.
interface aes_encrypt_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext, busy
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext, busy
  );
endinterface

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption: one round per clock with on-the-fly forward
// key expansion. A block is taken in IDLE (initial AddRoundKey on the accept
// edge), runs ten rounds in ROUND and is held in DONE until consumed.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : aes_encrypt_iter_if.slave (in/out valid-ready handshakes, busy)
module aes_encrypt_iter (
  input logic              clk,
  input logic              rst,
  aes_encrypt_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm;
  logic [3:0]   round;
  logic [127:0] state_reg;
  logic [127:0] rk_reg;

  logic [127:0] rk_next;
  logic [127:0] sr_state;
  logic [127:0] mid_state;
  logic [127:0] last_state;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as the GF(2^8) inverse (a^254, which maps 0 to 0)
  // followed by the affine transform, so no lookup table has to be carried.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte index r + 4*c; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    // RotWord brings byte 1 to the front before substitution.
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign rk_next    = key_expand(rk_reg, rcon(round));
  assign sr_state   = shift_rows(sub_bytes(state_reg));
  assign mid_state  = mix_columns(sr_state) ^ rk_next;
  assign last_state = sr_state ^ rk_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      round     <= 4'd0;
      state_reg <= '0;
      rk_reg    <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.in_valid) begin
            state_reg <= bus.plaintext ^ bus.key;
            rk_reg    <= bus.key;
            round     <= 4'd1;
            fsm       <= ROUND;
          end
        end
        ROUND: begin
          rk_reg <= rk_next;
          if (round == 4'd10) begin
            state_reg <= last_state;
            round     <= 4'd0;
            fsm       <= DONE;
          end else begin
            state_reg <= mid_state;
            round     <= round + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // in_ready is masked by rst so a block offered during reset is not
  // advertised as accepted.
  assign bus.in_ready   = (fsm == IDLE) && !rst;
  assign bus.out_valid  = (fsm == DONE);
  assign bus.busy       = (fsm != IDLE);
  assign bus.ciphertext = (fsm == DONE) ? state_reg : 128'h0;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Scoreboard bench for aes_encrypt_iter: directed FIPS-197 vectors, handshake
// timing, reset mid-block, then random blocks against a software AES-128 model.
module tb_aes_encrypt_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_encrypt_iter_if bus_if ();

  aes_encrypt_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  typedef struct {
    logic [127:0] ct;
    int           acc;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cycle    = 0;
  int         last_acc = 0;
  bit         rand_rdy = 1'b0;
  logic [7:0] sbox_t [256];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from log/antilog tables (generator 3) plus bitwise affine map.
  task automatic build_sbox();
    logic [7:0] ex [256];
    int         lg [256];
    logic [7:0] x, b, s, c;
    x = 8'h01;
    c = 8'h63;
    for (int i = 0; i < 256; i++) lg[i] = 0;
    for (int i = 0; i < 255; i++) begin
      ex[i] = x;
      lg[x] = i;
      x = x ^ xt(x);
    end
    for (int a = 0; a < 256; a++) begin
      b = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
      for (int i = 0; i < 8; i++)
        s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
      sbox_t[a] = s;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   w [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      w[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ w[i];
    end
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      tmp[0] = sbox_t[w[13]] ^ rc;
      tmp[1] = sbox_t[w[14]];
      tmp[2] = sbox_t[w[15]];
      tmp[3] = sbox_t[w[12]];
      for (int j = 0; j < 4; j++) w[j] = w[j] ^ tmp[j];
      for (int i = 4; i < 16; i++) w[i] = w[i] ^ w[i-4];
      rc = xt(rc);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r+4*c] = sbox_t[s[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Offer a block; push its expected result when the handshake is seen.
  task automatic send(input logic [127:0] pt, input logic [127:0] k,
                      input logic [127:0] ct, input bit hold);
    bus_if.in_valid  = 1'b1;
    bus_if.plaintext = pt;
    bus_if.key       = k;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus_if.in_ready) begin
        sb_q.push_back('{ct, cycle + 1});
        last_acc = cycle + 1;
        @(posedge clk);
        #1;
        if (!hold) bus_if.in_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 128'd0, 128'd1);
    bus_if.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !bus_if.out_valid) done = 1'b1;
    end
    chk("drain", 128'(done), 128'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: gating, hold stability, latency and scoreboard compare.
  initial begin
    logic [127:0] held_ct;
    bit           holding;
    bit           prev_ov;
    exp_t         e;
    holding = 1'b0;
    prev_ov = 1'b0;
    held_ct = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        holding = 1'b0;
        prev_ov = 1'b0;
      end else begin
        if (!bus_if.out_valid) chk("ct_gated", bus_if.ciphertext, 128'h0);
        if (holding) begin
          chk("hold_valid", 128'(bus_if.out_valid), 128'd1);
          chk("hold_ct", bus_if.ciphertext, held_ct);
        end
        if (bus_if.out_valid && !prev_ov) begin
          if (sb_q.size() == 0) chk("unexpected_out", 128'd1, 128'd0);
          else chk("latency", 128'(cycle - sb_q[0].acc), 128'd10);
        end
        if (bus_if.out_valid && bus_if.out_ready) begin
          if (sb_q.size() == 0) chk("unexpected_out", 128'd1, 128'd0);
          else begin
            e = sb_q.pop_front();
            chk("ciphertext", bus_if.ciphertext, e.ct);
          end
          holding = 1'b0;
        end else begin
          holding = bus_if.out_valid;
          held_ct = bus_if.ciphertext;
        end
        prev_ov = bus_if.out_valid;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus_if.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int           a1;
    int           gap;
    bit           seen;
    logic [127:0] pt, k;

    bus_if.in_valid  = 1'b0;
    bus_if.plaintext = '0;
    bus_if.key       = '0;
    bus_if.out_ready = 1'b1;
    build_sbox();

    chk("model_c1", aes_ref(C1_PT, C1_KEY), C1_CT);
    chk("model_b", aes_ref(B_PT, B_KEY), B_CT);
    chk("model_zero", aes_ref(128'h0, 128'h0), Z_CT);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(bus_if.in_ready), 128'd0);
    chk("rst_out_valid", 128'(bus_if.out_valid), 128'd0);
    chk("rst_busy", 128'(bus_if.busy), 128'd0);
    chk("rst_ct", bus_if.ciphertext, 128'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 128'(bus_if.in_ready), 128'd1);

    // FIPS-197 C.1
    send(C1_PT, C1_KEY, C1_CT, 1'b0);
    chk("busy_in_round", 128'(bus_if.busy), 128'd1);
    chk("in_ready_in_round", 128'(bus_if.in_ready), 128'd0);
    wait_drain();

    // App. B with out_ready held low for 5 cycles
    bus_if.out_ready = 1'b0;
    send(B_PT, B_KEY, B_CT, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.out_valid) seen = 1'b1;
    end
    chk("b_out_valid_seen", 128'(seen), 128'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("b_busy_in_done", 128'(bus_if.busy), 128'd1);
    chk("b_in_ready_in_done", 128'(bus_if.in_ready), 128'd0);
    bus_if.out_ready = 1'b1;
    wait_drain();

    // All-zero key and plaintext
    send(128'h0, 128'h0, Z_CT, 1'b0);
    wait_drain();

    // Back-to-back with in_valid held; second vector appears during ROUND
    send(C1_PT, C1_KEY, C1_CT, 1'b1);
    a1 = last_acc;
    send(B_PT, B_KEY, B_CT, 1'b0);
    chk("b2b_gap", 128'(last_acc - a1), 128'd12);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bus_if.in_valid  = ~bus_if.in_valid;
      bus_if.plaintext = {$urandom, $urandom, $urandom, $urandom};
      bus_if.key       = {$urandom, $urandom, $urandom, $urandom};
    end
    bus_if.in_valid = 1'b0;
    wait_drain();

    // Reset in the middle of the rounds
    send(C1_PT, C1_KEY, C1_CT, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready_low", 128'(bus_if.in_ready), 128'd0);
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 128'(bus_if.out_valid), 128'd0);
    chk("midrst_busy", 128'(bus_if.busy), 128'd0);
    chk("midrst_ct", bus_if.ciphertext, 128'h0);
    sb_q.delete();
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 128'(bus_if.in_ready), 128'd1);
    send(C1_PT, C1_KEY, C1_CT, 1'b0);
    wait_drain();

    // Random blocks against the software model
    rand_rdy = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      pt = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      send(pt, k, aes_ref(pt, k), 1'b0);
    end
    wait_drain();
    rand_rdy = 1'b0;
    bus_if.out_ready = 1'b1;

    chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
